// File: rtl/hdmi_pkg.sv
// Shared types and timing constants for the HDMI data-island scheduler.
package hdmi_pkg;

    // Scheduler phases, in the order a complete island walks through them.
    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        LEAD_GB,
        PACKET,
        TRAIL_GB,
        GAP
    } state_t;

    localparam int PREAMBLE_LEN = 8;
    localparam int GB_LEN       = 2;
    localparam int PKT_LEN      = 32;
    localparam int GAP_LEN      = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick, registered last-granted pointer.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    localparam int IDX_W  = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic               update,
    output logic               pick_valid,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [IDX_W-1:0] last;

    // Search from the source after the last winner; walking the offsets
    // downwards lets the nearest asserted request overwrite farther ones.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latch).
        pick_valid = 1'b0;
        pick_idx   = last;
        for (int i = NUM_SRC; i >= 1; i--) begin
            if (req[(int'(last) + i) % NUM_SRC]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((int'(last) + i) % NUM_SRC);
            end
        end
    end

    // Remember the winner; resetting to the top index gives source 0 first turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IDX_W'(NUM_SRC - 1);
        end else if (update) begin
            // NOTE: registered state uses non-blocking assignment.
            last <= pick_idx;
        end
    end

endmodule

// File: rtl/data_island_scheduler.sv
// Schedules HDMI data islands inside blanking: preamble, guard bands,
// round-robin packet grants and the trailing gap before the next island.
module data_island_scheduler
    import hdmi_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int MAX_PACKETS = 18,
    parameter int CTL_MIN     = 12
) (
    input  logic                       clk_pixel,
    input  logic                       reset_n,
    input  logic                       blank,
    input  logic [11:0]                blank_remaining,
    input  logic [NUM_SRC-1:0]         req,
    output logic [NUM_SRC-1:0]         grant,
    output logic [$clog2(NUM_SRC)-1:0] sel,
    output logic                       preamble,
    output logic                       guard_band,
    output logic                       data_island_period,
    output logic [4:0]                 pkt_counter,
    output logic                       overrun
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_PACKETS + 1);

    // An island needs 8+2+32+2 pixels plus the control period behind it;
    // a further packet needs 32+2 more after the current pixel.
    localparam logic [11:0]      START_MIN = 12'(44 + CTL_MIN);
    localparam logic [11:0]      NEXT_MIN  = 12'(35 + CTL_MIN);
    localparam logic [2:0]       PRE_LAST  = 3'(PREAMBLE_LEN - 1);
    localparam logic [2:0]       GB_LAST   = 3'(GB_LEN - 1);
    localparam logic [2:0]       GAP_LAST  = 3'(GAP_LEN - 1);
    localparam logic [4:0]       PKT_LAST  = 5'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] PKT_MAX   = CNT_W'(MAX_PACKETS);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    state_t           state;
    logic [2:0]       phase;
    logic [CNT_W-1:0] pkt_sent;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             abort;
    logic             start;
    logic             lead_last;
    logic             pkt_last;
    logic             next_ok;
    logic             grant_en;

    // Assert immediately, release two clocks later in step with clk_pixel.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        // NOTE: async assert / sync deassert avoids recovery violations on release.
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    assign abort     = (state inside {PREAMBLE, LEAD_GB, PACKET, TRAIL_GB}) && !blank;
    assign start     = (state == IDLE) && blank && (|req) && (blank_remaining >= START_MIN);
    assign lead_last = (state == LEAD_GB) && (phase == GB_LAST);
    assign pkt_last  = (state == PACKET) && (pkt_counter == PKT_LAST);
    assign next_ok   = (pkt_sent < PKT_MAX) && (blank_remaining >= NEXT_MIN);
    assign grant_en  = blank && pick_valid && (lead_last || (pkt_last && next_ok));
    assign grant     = grant_en ? (NUM_SRC'(1) << pick_idx) : '0;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .clk        (clk_pixel),
        .rst_n      (rst_int_n),
        .req        (req),
        .update     (grant_en),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Island sequencer with registered control outputs.
    always_ff @(posedge clk_pixel or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state              <= IDLE;
            phase              <= '0;
            pkt_sent           <= '0;
            sel                <= '0;
            preamble           <= 1'b0;
            guard_band         <= 1'b0;
            data_island_period <= 1'b0;
            pkt_counter        <= '0;
            overrun            <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (grant_en) sel <= pick_idx;

            if (abort) begin
                state              <= IDLE;
                phase              <= '0;
                preamble           <= 1'b0;
                guard_band         <= 1'b0;
                data_island_period <= 1'b0;
                pkt_counter        <= '0;
                overrun            <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= PREAMBLE;
                            phase    <= '0;
                            preamble <= 1'b1;
                        end
                    end
                    PREAMBLE: begin
                        if (phase == PRE_LAST) begin
                            state      <= LEAD_GB;
                            phase      <= '0;
                            preamble   <= 1'b0;
                            guard_band <= 1'b1;
                        end else begin
                            phase <= phase + 3'd1;
                        end
                    end
                    LEAD_GB: begin
                        // The first packet always goes out, empty if nobody was granted.
                        if (phase == GB_LAST) begin
                            state              <= PACKET;
                            phase              <= '0;
                            guard_band         <= 1'b0;
                            data_island_period <= 1'b1;
                            pkt_counter        <= '0;
                            pkt_sent           <= CNT_W'(1);
                        end else begin
                            phase <= phase + 3'd1;
                        end
                    end
                    PACKET: begin
                        if (!pkt_last) begin
                            pkt_counter <= pkt_counter + 5'd1;
                        end else if (grant_en) begin
                            pkt_counter <= '0;
                            pkt_sent    <= pkt_sent + CNT_W'(1);
                        end else begin
                            state              <= TRAIL_GB;
                            data_island_period <= 1'b0;
                            guard_band         <= 1'b1;
                            pkt_counter        <= '0;
                        end
                    end
                    TRAIL_GB: begin
                        if (phase == GB_LAST) begin
                            state      <= GAP;
                            phase      <= '0;
                            guard_band <= 1'b0;
                        end else begin
                            phase <= phase + 3'd1;
                        end
                    end
                    GAP: begin
                        if (phase == GAP_LAST) begin
                            state <= IDLE;
                            phase <= '0;
                        end else begin
                            phase <= phase + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Self-checking bench for data_island_scheduler: directed scenarios plus a
// randomized blanking/request run, all checked against an island-timeline model.
module tb_data_island_scheduler;

    localparam int N    = 4;
    localparam int MAXP = 18;
    localparam int CTL  = 12;

    logic        clk_pixel = 1'b0;
    logic        reset_n   = 1'b0;
    logic        blank     = 1'b0;
    logic [11:0] blank_remaining = '0;
    logic [3:0]  req       = '0;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        preamble;
    logic        guard_band;
    logic        data_island_period;
    logic [4:0]  pkt_counter;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    // Model: an island is a timeline indexed by offset o from its start.
    // o=1..8 preamble, 9..10 lead guard, then 32*npk packet pixels,
    // 2 trailing guard pixels and 4 gap pixels.
    bit         m_act;
    int         m_o;
    int         m_npk;
    int         m_last;
    int         m_sel;
    bit         m_ov;
    logic [3:0] m_grant;

    int grant_log[$];
    int n_grants;
    int first_grant_k;
    int first_pre_k;

    data_island_scheduler #(.NUM_SRC(N), .MAX_PACKETS(MAXP), .CTL_MIN(CTL)) dut (
        .clk_pixel          (clk_pixel),
        .reset_n            (reset_n),
        .blank              (blank),
        .blank_remaining    (blank_remaining),
        .req                (req),
        .grant              (grant),
        .sel                (sel),
        .preamble           (preamble),
        .guard_band         (guard_band),
        .data_island_period (data_island_period),
        .pkt_counter        (pkt_counter),
        .overrun            (overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(m_last + i) % N]) return (m_last + i) % N;
        end
        return -1;
    endfunction

    task automatic m_init();
        m_act   = 1'b0;
        m_o     = 0;
        m_npk   = 0;
        m_last  = N - 1;
        m_sel   = 0;
        m_ov    = 1'b0;
        m_grant = '0;
    endtask

    // One pixel: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        bit   pre, lead, inpkt, trail, gap;
        int   pend, g, epc;
        logic [3:0] eg;
        @(negedge clk_pixel);
        pend  = 10 + 32 * m_npk;
        pre   = m_act && m_o >= 1 && m_o <= 8;
        lead  = m_act && m_o >= 9 && m_o <= 10;
        inpkt = m_act && m_o >= 11 && m_o <= pend;
        trail = m_act && m_o > pend && m_o <= pend + 2;
        gap   = m_act && m_o > pend + 2;
        epc   = inpkt ? (m_o - 11) % 32 : 0;
        g = -1;
        if (blank && (|req)) begin
            if (lead && m_o == 10) g = rr_pick(req);
            else if (inpkt && m_o == pend && m_npk < MAXP && blank_remaining >= 12'(35 + CTL))
                g = rr_pick(req);
        end
        eg      = (g >= 0) ? 4'(1 << g) : 4'b0000;
        m_grant = eg;

        check("preamble", preamble, pre);
        check("guard_band", guard_band, lead || trail);
        check("data_island_period", data_island_period, inpkt);
        check("pkt_counter", pkt_counter, epc);
        check("grant", grant, eg);
        check("sel", sel, m_sel);
        check("overrun", overrun, m_ov);

        if (grant != 4'b0000) begin
            n_grants++;
            for (int j = 0; j < N; j++) if (grant[j]) grant_log.push_back(j);
        end

        if (m_act && !gap && !blank) begin
            m_act = 1'b0;
            m_ov  = 1'b1;
        end else begin
            m_ov = 1'b0;
            if (m_act) begin
                if (m_o == 10) m_npk = 1;
                if (g >= 0) begin
                    m_last = g;
                    m_sel  = g;
                    if (inpkt) m_npk++;
                end
                m_o++;
                if (m_o > 32 * m_npk + 16) m_act = 1'b0;
            end else if (blank && (|req) && blank_remaining >= 12'(44 + CTL)) begin
                m_act = 1'b1;
                m_o   = 1;
                m_npk = 0;
            end
        end
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        blank = 1'b0; blank_remaining = '0; req = '0;
        repeat (3) @(posedge clk_pixel);
        #1;
        check("reset_outputs",
              {grant, sel, preamble, guard_band, data_island_period, pkt_counter, overrun}, 0);
        reset_n = 1'b1;
        m_init();
        repeat (4) step();
    endtask

    task automatic quiet(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            blank = 1'b0; blank_remaining = '0; req = '0;
            step();
        end
    endtask

    // Blanking interval counting down from br0; when hold=0 a granted request drops.
    task automatic run_blank(input int br0, input logic [3:0] r, input int cycles, input bit hold);
        n_grants      = 0;
        first_grant_k = -1;
        first_pre_k   = -1;
        req = r;
        for (int k = 0; k < cycles; k++) begin
            if (br0 - k > 0) begin
                blank = 1'b1; blank_remaining = 12'(br0 - k);
            end else begin
                blank = 1'b0; blank_remaining = '0;
            end
            step();
            if (first_grant_k < 0 && n_grants > 0) first_grant_k = k;
            if (!hold) req = req & ~m_grant;
            if (first_pre_k < 0 && preamble) first_pre_k = k + 1;
        end
    endtask

    initial begin
        int blen, vlen;
        m_init();
        do_reset();

        // Single request, one packet, exact island timing.
        run_blank(200, 4'b0001, 50, 1'b0);
        check("single_first_preamble_cycle", first_pre_k, 1);
        check("single_grant_cycle", first_grant_k, 10);
        check("single_grant_count", n_grants, 1);

        // Too little blanking left: never starts.
        quiet(2);
        run_blank(55, 4'b0001, 8, 1'b1);
        check("short_blank_no_preamble", first_pre_k, -1);
        quiet(2);

        // All sources held: round-robin order, 18 packets, then gap and a new island.
        do_reset();
        grant_log.delete();
        run_blank(1000, 4'b1111, 600, 1'b1);
        check("full_island_packets", grant_log.size(), MAXP);
        for (int k = 0; k < MAXP && k < grant_log.size(); k++)
            check("rr_order", grant_log[k], k % N);
        run_blank(400, 4'b1111, 20, 1'b1);
        check("second_island_started", n_grants, 1);
        quiet(3);

        // Blank budget runs short at the packet boundary.
        run_blank(88, 4'b0011, 60, 1'b1);
        check("budget_single_packet", n_grants, 1);
        quiet(2);

        // Blank drops in the middle of a packet.
        run_blank(300, 4'b0001, 21, 1'b0);
        check("abort_pkt_counter", pkt_counter, 10);
        blank = 1'b0; blank_remaining = '0; req = '0;
        step();
        check("abort_overrun", overrun, 1);
        check("abort_outputs", {preamble, guard_band, data_island_period, pkt_counter}, 0);
        step();
        check("abort_overrun_pulse", overrun, 0);
        quiet(2);

        // Null packet when the request vanishes before the lead guard decision.
        run_blank(200, 4'b0100, 50, 1'b0);
        quiet(2);
        run_blank(300, 4'b0001, 10, 1'b1);
        run_blank(290, 4'b0000, 40, 1'b1);
        check("null_packet_no_grant", n_grants, 0);
        check("null_packet_sel_kept", sel, 2);
        quiet(2);

        // Reset in the middle of a packet clears outputs immediately.
        run_blank(300, 4'b0001, 16, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midpkt_reset_outputs",
              {grant, sel, preamble, guard_band, data_island_period, pkt_counter, overrun}, 0);
        do_reset();

        // Randomized blanking intervals and requests.
        blen = 0;
        vlen = 5;
        for (int c = 0; c < 2500; c++) begin
            if (blen > 0) begin
                blank = 1'b1; blank_remaining = 12'(blen); blen--;
            end else begin
                blank = 1'b0; blank_remaining = '0;
                if (vlen > 0) vlen--;
                else begin
                    blen = int'($urandom_range(30, 700));
                    vlen = int'($urandom_range(3, 40));
                end
            end
            for (int s = 0; s < N; s++) begin
                if (req[s]) begin
                    if (m_grant[s]) req[s] = 1'($urandom_range(0, 1));
                    else if ($urandom_range(0, 15) == 0) req[s] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req[s] = 1'b1;
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
